ps_axl_master: RTL and testbench
================================

PS_AXL_MASTER -- requirements
Module: ps_axl_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data width of requests and AXI-lite data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: watchdog limit, used only with AXL_TIMEOUT_EN.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  PS request valid.
REQ-008 req_ready  output  1  PS request accepted.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  target address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response taken.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_err  output  1  slave error or timeout.
REQ-016 waddr/wavalid/waready  out/out/in  ADDR_WIDTH/1/1  AXI-lite write-address channel.
REQ-017 wdata/wvalid/wready  out/out/in  DATA_WIDTH/1/1  AXI-lite write-data channel.
REQ-018 wresp/bvalid/bready  in/in/out  DATA_WIDTH/1/1  write response; bits [1:0] are the response code.
REQ-019 raddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read-address channel.
REQ-020 rdata/rvalid/rready  in/in/out  DATA_WIDTH/1/1  read-data channel.

Function
REQ-021 SHALL be the AXI-lite initiator, with one outstanding transaction only.
REQ-022 FSM states SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-023 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, addr/wdata/write SHALL be registered.
REQ-024 Write path: IDLE->WR_ADDR_DATA; wavalid and wvalid SHALL both rise on the cycle after acceptance.
REQ-025 wavalid and wvalid SHALL each drop independently after their own handshake, in any order or simultaneously.
REQ-026 The FSM SHALL move to WR_RESP when both channels have completed.
REQ-027 In WR_RESP, bready SHALL be 1; on bvalid, rsp_err SHALL latch (wresp[1:0]!=0) and the FSM SHALL go to RSP.
REQ-028 Read path: IDLE->RD_ADDR with arvalid=1 until arready, then RD_DATA with rready=1.
REQ-029 On rvalid, rdata SHALL latch into rsp_rdata, rsp_err SHALL be 0, and the FSM SHALL go to RSP.
REQ-030 In RSP, rsp_valid SHALL be 1 and held stable until rsp_ready, then the FSM SHALL return to IDLE.
REQ-031 Back-to-back requests SHALL be accepted no earlier than the cycle after the response handshake.
REQ-032 Latency with an always-ready slave: write rsp_valid SHALL assert 3 cycles after acceptance.
REQ-033 All AXI valid/ready outputs SHALL be driven from registers or state decode only, never combinationally from inputs.
REQ-034 Once asserted, a valid SHALL hold with stable payload until its handshake.

Reset
REQ-035 rst SHALL force the FSM to IDLE immediately, including mid-transaction.
REQ-036 During and after reset: wavalid, wvalid, arvalid, bready, rready, rsp_valid and rsp_err SHALL be 0, and rsp_rdata, waddr, raddr and wdata SHALL be 0.
REQ-037 req_ready SHALL be 0 while rst is high and SHALL be 1 on the first cycle after release.

Configuration
REQ-038 With AXL_TIMEOUT_EN defined, a counter SHALL run in every non-IDLE, non-RSP state and SHALL clear on entry to IDLE.
REQ-039 On reaching TIMEOUT_CYCLES, the block SHALL drop all AXI valids/readies, go to RSP with rsp_err=1, and return rsp_rdata=0.
REQ-040 Without AXL_TIMEOUT_EN, the block SHALL wait indefinitely, and the counter logic SHALL not exist.

Structure
REQ-041 Package ps_axl_pkg SHALL hold the state enum, the response-code constants (OKAY=2'b00, SLVERR=2'b10) and the default TIMEOUT_CYCLES.
REQ-042 Sub-module axl_timeout_ctr (counter plus expiry flag) SHALL be instantiated only under AXL_TIMEOUT_EN.

Verification
REQ-043 Write addr 0x4, data 0xDEADBEEF, slave always ready, wresp=0 -> wavalid/wvalid for 1 cycle, rsp_valid at +3 cycles, rsp_err=0.
REQ-044 Read addr 0x8, slave returns 0x12345678 after 5 wait cycles -> arvalid held until arready, rsp_rdata=0x12345678, rsp_err=0.
REQ-045 Write where waready comes 4 cycles after wready -> wvalid drops first, wavalid holds, bready only after both, exactly one write seen.
REQ-046 Write with wresp=2 and rsp_ready low 3 cycles -> rsp_err=1, rsp_valid/rsp_rdata stable, req_ready=0 throughout.
REQ-047 Assert rst while arvalid is high -> arvalid=0 in the same cycle, IDLE, req_ready=1 on the first cycle after release.
REQ-048 AXL_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a slave that never responds -> valids drop, rsp_err=1 after 16 cycles, then the next request completes normally.

Source files
------------

// File: rtl/ps_axl_pkg.sv
// Shared state encoding, AXI-lite response codes and watchdog defaults for the PS AXI-lite master.
// Latency: none (types, constants and a width helper only).
// Backpressure: none.
package ps_axl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } axl_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

    // Bits needed to count from 0 up to limit-1; never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/axl_timeout_ctr.sv
// Watchdog counter: counts cycles while run is high and flags expiry on the LIMIT-th such cycle.
// Latency: expired is combinational from the count, so the owner can leave a state on that same cycle.
// Backpressure: none; clr returns the count to zero and wins over run.
module axl_timeout_ctr
    import ps_axl_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned   CW   = ctr_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    // The count is the number of busy cycles already spent, so LAST means this is the LIMIT-th one.
    assign expired = run && (cnt == LAST);

    // Count busy cycles; freeze at LAST once expired so the value cannot wrap before the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps_axl_master.sv
// Bridges single PS requests onto AXI-lite as the initiator, one transaction in flight at a time.
// Latency: write with an always-ready slave gives rsp_valid 3 cycles after acceptance; reads follow the slave.
// Backpressure: req_ready only in IDLE; rsp_valid and its payload hold until rsp_ready.
// Build option: define AXL_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that aborts stalled transactions.
module ps_axl_master
    import ps_axl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    // PS request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // PS response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // AXI-lite write address
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wavalid,
    input  logic                  waready,
    // AXI-lite write data
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI-lite write response
    input  logic [DATA_WIDTH-1:0] wresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI-lite read address
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  arvalid,
    input  logic                  arready,
    // AXI-lite read data
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic                  rready
);

    axl_state_t state;
    axl_state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_pend;
    logic                  w_pend;

    logic accept;
    logic timeout;
    logic aw_fin;
    logic w_fin;
    logic unused_bits;

    // Request handshake; held off during reset even though the state already reads IDLE.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // A write channel is finished once its valid has gone, or its handshake completes this cycle.
    assign aw_fin = !aw_pend || waready;
    assign w_fin  = !w_pend  || wready;

`ifdef AXL_TIMEOUT_EN
    logic busy;

    assign busy = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                  (state == RD_ADDR)      || (state == RD_DATA);

    axl_timeout_ctr #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .clr     (state == IDLE),
        .expired (timeout)
    );

    assign unused_bits = &{1'b0, wresp[DATA_WIDTH-1:2]};
`else
    // No watchdog: a silent slave stalls the master indefinitely.
    assign timeout     = 1'b0;
    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    assign unused_bits = &{1'b0, wresp[DATA_WIDTH-1:2], TIMEOUT_CYCLES[0]};
`endif

    // State register; reset drops any transaction in flight straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the watchdog overrides every slave-wait state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (timeout) begin
                    state_nxt = RSP;
                end else if (aw_fin && w_fin) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (timeout || bvalid) begin
                    state_nxt = RSP;
                end
            end
            RD_ADDR: begin
                if (timeout) begin
                    state_nxt = RSP;
                end else if (arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (timeout || rvalid) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, per-channel write valids and response latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                aw_pend <= req_write;
                w_pend  <= req_write;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (timeout) begin
                aw_pend <= 1'b0;
                w_pend  <= 1'b0;
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else begin
                // Address and data retire independently, in either order.
                if (aw_pend && waready) begin
                    aw_pend <= 1'b0;
                end
                if (w_pend && wready) begin
                    w_pend <= 1'b0;
                end
                if ((state == WR_RESP) && bvalid) begin
                    err_q <= (wresp[1:0] != RESP_OKAY);
                end
                if ((state == RD_DATA) && rvalid) begin
                    rdata_q <= rdata;
                    err_q   <= 1'b0;
                end
            end
        end
    end

    // Every AXI valid/ready is a flop or a state decode, never a path from an input.
    assign wavalid   = aw_pend;
    assign wvalid    = w_pend;
    assign bready    = (state == WR_RESP);
    assign arvalid   = (state == RD_ADDR);
    assign rready    = (state == RD_DATA);
    assign rsp_valid = (state == RSP);

    assign waddr     = addr_q;
    assign raddr     = addr_q;
    assign wdata     = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ps_axl_master.sv
// Self-checking bench for ps_axl_master: scoreboarded responses plus an AXI-lite slave model.
// Latency: n/a.
// Backpressure: slave readiness and rsp_ready are driven per test.
module tb_ps_axl_master;
    import ps_axl_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TMO = 16;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] waddr;
    logic          wavalid;
    logic          waready   = 1'b0;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready    = 1'b0;
    logic [DW-1:0] wresp     = '0;
    logic          bvalid    = 1'b0;
    logic          bready;
    logic [AW-1:0] raddr;
    logic          arvalid;
    logic          arready   = 1'b0;
    logic [DW-1:0] rdata     = '0;
    logic          rvalid    = 1'b0;
    logic          rready;

    ps_axl_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .waddr     (waddr),
        .wavalid   (wavalid),
        .waready   (waready),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .wresp     (wresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .raddr     (raddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_vec = 0;
    int n_err = 0;

    // Slave behaviour knobs
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  b_code = RESP_OKAY;
    logic [31:0] r_val  = '0;
    bit          mute   = 1'b0;

    // Slave internal state
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;

    // Observations
    int wav_n = 0, wv_n = 0, arv_n = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0;
    bit p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0;
    logic [AW-1:0] p_waddr = '0, p_raddr = '0;
    logic [DW-1:0] p_wdata = '0, p_rdata = '0;
    logic          p_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        wav_n = 0; wv_n = 0; arv_n = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
    endtask

    // Slave model and monitors: inputs change at the falling edge, handshakes land on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            waready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            wresp = '0; rdata = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
        end else begin
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (aw_got && w_got && !bvalid) begin
                bvalid = 1; wresp = {30'd0, b_code}; aw_got = 0; w_got = 0;
            end
            if (ar_got && !rvalid) begin
                if (r_cnt >= r_lat) begin
                    rvalid = 1; rdata = r_val; ar_got = 0; r_cnt = 0;
                end else begin
                    r_cnt++;
                end
            end
            if (wavalid) begin waready = !mute && (aw_cnt >= aw_lat); aw_cnt++; wav_n++; end
            else begin waready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = !mute && (w_cnt >= w_lat); w_cnt++; wv_n++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = !mute && (ar_cnt >= ar_lat); ar_cnt++; arv_n++; end
            else begin arready = 0; ar_cnt = 0; end
            if (wavalid && waready) begin aw_got = 1; aw_hs++; end
            if (wvalid && wready) begin w_got = 1; w_hs++; end
            if (arvalid && arready) begin ar_got = 1; ar_hs++; end
            b_fire = bvalid && bready;
            r_fire = rvalid && rready;

            if (p_aw && (!wavalid || waddr !== p_waddr)) viol++;
            if (p_w && (!wvalid || wdata !== p_wdata)) viol++;
            if (p_ar && (!arvalid || raddr !== p_raddr)) viol++;
            if (p_rsp && (!rsp_valid || rsp_rdata !== p_rdata || rsp_err !== p_err)) viol++;
            if (bready && (wavalid || wvalid)) viol++;
            if (req_ready && rsp_valid) viol++;
            p_aw = wavalid && !waready;     p_waddr = waddr;
            p_w  = wvalid && !wready;       p_wdata = wdata;
            p_ar = arvalid && !arready;     p_raddr = raddr;
            p_rsp = rsp_valid && !rsp_ready; p_rdata = rsp_rdata; p_err = rsp_err;

            if (rsp_valid && rsp_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Present one request, record its expected response, return one step after the acceptance edge.
    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rdata, input bit exp_err);
        int n;
        exp_t x;
        x.rdata = exp_rdata;
        x.err   = exp_err;
        sb.push_back(x);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("req_accepted", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // Cycle index of first rsp_valid, counting the acceptance cycle as 0.
    task automatic rsp_latency(output int n);
        n = 1;
        while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin @(posedge clk); #1; n++; end
        chk("idle_reached", 32'(sb.size() == 0 && req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int n;

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wavalid", 32'(wavalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_bready", 32'(bready), 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_waddr_raddr", 32'({waddr, raddr}), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 0;
        #1;
        chk("rel_req_ready", 32'(req_ready), 1);

        // Plain write, always-ready slave
        clear_stats();
        do_req(1'b1, 4'h4, 32'hDEADBEEF, 32'h0, 1'b0);
        rsp_latency(lat);
        chk("wr_latency", 32'(lat), 3);
        wait_idle();
        chk("wr_wavalid_cycles", 32'(wav_n), 1);
        chk("wr_wvalid_cycles", 32'(wv_n), 1);
        chk("wr_handshakes", 32'(aw_hs + w_hs), 2);
        chk("wr_waddr", 32'(waddr), 32'h4);
        chk("wr_wdata", wdata, 32'hDEADBEEF);

        // Read with a slow address channel and delayed data
        clear_stats();
        ar_lat = 5; r_lat = 2; r_val = 32'h12345678;
        do_req(1'b0, 4'h8, 32'h0, 32'h12345678, 1'b0);
        wait_idle();
        chk("rd_arvalid_cycles", 32'(arv_n), 6);
        chk("rd_ar_handshakes", 32'(ar_hs), 1);
        chk("rd_raddr", 32'(raddr), 32'h8);
        ar_lat = 0; r_lat = 0;

        // Write whose address channel lags the data channel by 4 cycles
        clear_stats();
        aw_lat = 4;
        do_req(1'b1, 4'hC, 32'hA5A50001, 32'h0, 1'b0);
        wait_idle();
        chk("split_wvalid_cycles", 32'(wv_n), 1);
        chk("split_wavalid_cycles", 32'(wav_n), 5);
        chk("split_aw_hs", 32'(aw_hs), 1);
        chk("split_w_hs", 32'(w_hs), 1);
        aw_lat = 0;

        // Slave error with a stalled response consumer
        b_code = RESP_SLVERR;
        rsp_ready = 0;
        do_req(1'b1, 4'h3, 32'h00000011, 32'h0, 1'b1);
        rsp_latency(lat);
        chk("err_rsp_seen", 32'(rsp_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("err_hold_rsp_valid", 32'(rsp_valid), 1);
            chk("err_hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1;
        wait_idle();
        b_code = RESP_OKAY;

        // Back-to-back read, write, read: the write must report rdata 0
        r_val = 32'hCAFEF00D;
        do_req(1'b0, 4'h1, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req(1'b1, 4'h2, 32'h00000055, 32'h0, 1'b0);
        do_req(1'b0, 4'h3, 32'h0, 32'hCAFEF00D, 1'b0);
        wait_idle();

        // Reset in the middle of a read address phase
        ar_lat = 50;
        do_req(1'b0, 4'h5, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (!arvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("mid_arvalid_up", 32'(arvalid), 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("mid_rst_arvalid", 32'(arvalid), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("mid_rel_req_ready", 32'(req_ready), 1);
        ar_lat = 0;
        do_req(1'b0, 4'h6, 32'h0, 32'hCAFEF00D, 1'b0);
        wait_idle();

`ifdef AXL_TIMEOUT_EN
        // Slave that never answers: watchdog aborts, then normal traffic resumes
        mute = 1;
        clear_stats();
        do_req(1'b0, 4'h2, 32'h0, 32'h0, 1'b1);
        rsp_latency(lat);
        chk("tmo_rd_latency", 32'(lat), 17);
        wait_idle();
        chk("tmo_rd_arvalid_cycles", 32'(arv_n), TMO);
        clear_stats();
        do_req(1'b1, 4'h7, 32'h00000077, 32'h0, 1'b1);
        wait_idle();
        chk("tmo_wr_wavalid_cycles", 32'(wav_n), TMO);
        chk("tmo_wr_wvalid_cycles", 32'(wv_n), TMO);
        chk("tmo_wr_bready_never", 32'(aw_hs + w_hs), 0);
        mute = 0;
        do_req(1'b1, 4'h7, 32'h00000077, 32'h0, 1'b0);
        do_req(1'b0, 4'h7, 32'h0, 32'hCAFEF00D, 1'b0);
        wait_idle();
`endif

        chk("protocol_violations", 32'(viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "tb_ps_axl_master time limit");
    end

endmodule
